axi_w_upsizer_packer: RTL and testbench

- Write-data path of an AXI data-width upsizer, the opposite direction of the existing downsizer.
- Accepts one command per AW burst and narrow W beats from the slave side.
- Packs the narrow beats into wide W beats with merged strobes for the wider master-side bus.
- Sits after AW address translation; AW forwarding and B handling live elsewhere.

---
 rtl/axi_pkg.sv | 13 +
 rtl/fifo_v3.sv | 62 ++++++
 rtl/axi_w_upsizer_packer.sv | 240 ++++++++++++++++++++++++
 tb/tb_axi_w_upsizer_packer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// AXI type definitions shared by the width converters.
// Contents: burst length, beat size and burst type encodings.
package axi_pkg;

   typedef logic [7:0] len_t;
   typedef logic [2:0] size_t;
   typedef logic [1:0] burst_t;

   localparam burst_t BURST_FIXED = 2'b00;
   localparam burst_t BURST_INCR  = 2'b01;
   localparam burst_t BURST_WRAP  = 2'b10;

endpackage

// File: rtl/fifo_v3.sv
// Synchronous FIFO with registered occupancy.
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   full_o, empty_o  occupancy flags, derived from the occupancy register
//   data_i, push_i   write side; a push while full is ignored
//   data_o, pop_i    read side (head entry); a pop while empty is ignored
module fifo_v3 #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   output logic                  full_o,
   output logic                  empty_o,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  push_i,
   output logic [DATA_WIDTH-1:0] data_o,
   input  logic                  pop_i
);

   localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW  = $clog2(DEPTH + 1);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [AddrW-1:0]      rd_ptr_q;
   logic [AddrW-1:0]      wr_ptr_q;
   logic [CntW-1:0]       cnt_q;
   logic                  push_ok;
   logic                  pop_ok;

   assign full_o  = (cnt_q == CntW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign data_o  = mem_q[rd_ptr_q];
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;

   // Pointer and occupancy update; pointers wrap explicitly so any DEPTH works.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q <= (wr_ptr_q == AddrW'(DEPTH - 1)) ? '0 : wr_ptr_q + AddrW'(1);
         end
         if (pop_ok) begin
            rd_ptr_q <= (rd_ptr_q == AddrW'(DEPTH - 1)) ? '0 : rd_ptr_q + AddrW'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   cnt_q <= cnt_q + CntW'(1);
            2'b01:   cnt_q <= cnt_q - CntW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/axi_w_upsizer_packer.sv
// Write-data packer of an AXI upsizer: gathers narrow W beats of one AW burst
// into wide W beats with merged strobes. One command per burst is queued on
// the cmd port; AW forwarding and B handling are done elsewhere.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   cmd_*                   burst command (address low bits, len, size, burst)
//   slv_w_*                 narrow W channel (slave side)
//   mst_w_*                 wide W channel (master side), all outputs registered
//   err_o                   sticky last-vs-length mismatch flag
// Build option: AXI_W_UPSIZER_LAST_CHECK_EN derives burst termination from the
// len counter and flags mismatches on err_o; otherwise termination follows
// slv_w_last_i and err_o is tied low.
module axi_w_upsizer_packer
   import axi_pkg::*;
#(
   parameter int unsigned NarrowDataWidth = 32,
   parameter int unsigned WideDataWidth   = 256,
   parameter int unsigned UserWidth       = 8,
   parameter int unsigned CmdDepth        = 2
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic                                 cmd_valid_i,
   output logic                                 cmd_ready_o,
   input  logic [$clog2(WideDataWidth/8)-1:0]   cmd_offset_i,
   input  logic [7:0]                           cmd_len_i,
   input  logic [2:0]                           cmd_size_i,
   input  logic [1:0]                           cmd_burst_i,
   input  logic [NarrowDataWidth-1:0]           slv_w_data_i,
   input  logic [NarrowDataWidth/8-1:0]         slv_w_strb_i,
   input  logic                                 slv_w_last_i,
   input  logic [UserWidth-1:0]                 slv_w_user_i,
   input  logic                                 slv_w_valid_i,
   output logic                                 slv_w_ready_o,
   output logic [WideDataWidth-1:0]             mst_w_data_o,
   output logic [WideDataWidth/8-1:0]           mst_w_strb_o,
   output logic                                 mst_w_last_o,
   output logic [UserWidth-1:0]                 mst_w_user_o,
   output logic                                 mst_w_valid_o,
   input  logic                                 mst_w_ready_i,
   output logic                                 err_o
);

   localparam int unsigned NarrowBytes = NarrowDataWidth / 8;
   localparam int unsigned WideBytes   = WideDataWidth / 8;
   localparam int unsigned OffW        = $clog2(WideBytes);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] PACK = 2'd1;
   localparam logic [1:0] SEND = 2'd2;

   typedef struct packed {
      logic [OffW-1:0] offset;
      len_t            len;
      size_t           size;
      burst_t          burst;
   } cmd_t;

   cmd_t  cmd_in;
   cmd_t  cmd_head;
   logic  fifo_full;
   logic  fifo_empty;
   logic  fifo_pop;
   logic  rst_n;

   logic [1:0]                 state_q, state_d;
   logic [OffW-1:0]            offset_q, offset_d;
   len_t                       beats_q, beats_d;
   size_t                      size_q, size_d;
   burst_t                     burst_q, burst_d;
   logic [WideDataWidth-1:0]   data_d;
   logic [WideBytes-1:0]       strb_d;
   logic                       last_d;
   logic [UserWidth-1:0]       user_d;
   logic                       load;

   logic                       slv_hs;
   logic                       mst_hs;
   logic [OffW-1:0]            offset_inc;
   logic [OffW-1:0]            lane_base;
   logic [NarrowDataWidth-1:0] narrow_masked;
   logic [WideDataWidth-1:0]   data_sh;
   logic [WideBytes-1:0]       strb_sh;
   logic                       final_beat;
   logic                       flush;

   assign rst_n  = ~rst_i;
   assign cmd_in = '{offset: cmd_offset_i, len: cmd_len_i, size: cmd_size_i, burst: cmd_burst_i};
   assign cmd_ready_o = ~fifo_full;

   fifo_v3 #(
      .DATA_WIDTH ($bits(cmd_t)),
      .DEPTH      (CmdDepth)
   ) i_cmd_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_n),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .data_i  (cmd_in),
      .push_i  (cmd_valid_i),
      .data_o  (cmd_head),
      .pop_i   (fifo_pop)
   );

   // Zero disabled narrow bytes so they land as 0 in the wide beat.
   for (genvar j = 0; j < NarrowBytes; j++) begin : g_mask
      assign narrow_masked[j*8 +: 8] = slv_w_data_i[j*8 +: 8] & {8{slv_w_strb_i[j]}};
   end

   // Narrow lane position within the wide beat, aligned to the narrow bus width.
   assign lane_base  = offset_q & ~OffW'(NarrowBytes - 1);
   assign data_sh    = WideDataWidth'(narrow_masked) << {lane_base, 3'b000};
   assign strb_sh    = WideBytes'(slv_w_strb_i) << lane_base;
   assign offset_inc = offset_q + (OffW'(1) << size_q);

   assign slv_hs = slv_w_ready_o & slv_w_valid_i;
   assign mst_hs = mst_w_valid_o & mst_w_ready_i;

`ifdef AXI_W_UPSIZER_LAST_CHECK_EN
   logic err_d;
   assign final_beat = (beats_q == '0);
`else
   assign final_beat = slv_w_last_i;
   assign err_o      = 1'b0;
`endif

   // A wide beat leaves on the burst end, on every FIXED beat, or when the
   // incrementing address crosses into the next wide word.
   assign flush = final_beat | (burst_q == BURST_FIXED) | (offset_inc == '0);

   // Next-state and datapath update.
   always_comb begin
      state_d  = state_q;
      offset_d = offset_q;
      beats_d  = beats_q;
      size_d   = size_q;
      burst_d  = burst_q;
      data_d   = mst_w_data_o;
      strb_d   = mst_w_strb_o;
      last_d   = mst_w_last_o;
      user_d   = mst_w_user_o;
      fifo_pop = 1'b0;
      load     = 1'b0;
`ifdef AXI_W_UPSIZER_LAST_CHECK_EN
      err_d    = err_o;
`endif

      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               load = 1'b1;
            end
         end
         PACK: begin
            if (slv_hs) begin
               data_d  = mst_w_data_o | data_sh;
               strb_d  = mst_w_strb_o | strb_sh;
               user_d  = slv_w_user_i;
               beats_d = beats_q - 8'd1;
               if (burst_q != BURST_FIXED) begin
                  offset_d = offset_inc;
               end
               if (flush) begin
                  last_d  = final_beat;
                  state_d = SEND;
               end
`ifdef AXI_W_UPSIZER_LAST_CHECK_EN
               if (slv_w_last_i != (beats_q == '0)) begin
                  err_d = 1'b1;
               end
`endif
            end
         end
         SEND: begin
            if (mst_hs) begin
               data_d = '0;
               strb_d = '0;
               last_d = 1'b0;
               if (!mst_w_last_o) begin
                  state_d = PACK;
               end else if (!fifo_empty) begin
                  load = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Entry into PACK with a fresh command: pop it and start from an empty beat.
      if (load) begin
         fifo_pop = 1'b1;
         offset_d = cmd_head.offset;
         beats_d  = cmd_head.len;
         size_d   = cmd_head.size;
         burst_d  = cmd_head.burst;
         data_d   = '0;
         strb_d   = '0;
         last_d   = 1'b0;
         state_d  = PACK;
      end
   end

   // State, command context, and registered outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q       <= IDLE;
         offset_q      <= '0;
         beats_q       <= '0;
         size_q        <= '0;
         burst_q       <= BURST_FIXED;
         mst_w_data_o  <= '0;
         mst_w_strb_o  <= '0;
         mst_w_last_o  <= 1'b0;
         mst_w_user_o  <= '0;
         mst_w_valid_o <= 1'b0;
         slv_w_ready_o <= 1'b0;
`ifdef AXI_W_UPSIZER_LAST_CHECK_EN
         err_o         <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         offset_q      <= offset_d;
         beats_q       <= beats_d;
         size_q        <= size_d;
         burst_q       <= burst_d;
         mst_w_data_o  <= data_d;
         mst_w_strb_o  <= strb_d;
         mst_w_last_o  <= last_d;
         mst_w_user_o  <= user_d;
         mst_w_valid_o <= (state_d == SEND);
         slv_w_ready_o <= (state_d == PACK);
`ifdef AXI_W_UPSIZER_LAST_CHECK_EN
         err_o         <= err_d;
`endif
      end
   end

endmodule

// File: tb/tb_axi_w_upsizer_packer.sv
// Directed bench for axi_w_upsizer_packer with hand-computed expected beats.
module tb_axi_w_upsizer_packer;
   import axi_pkg::*;

   logic         clk;
   logic         rst;
   logic         cmd_valid;
   logic         cmd_ready_o;
   logic [4:0]   cmd_offset;
   logic [7:0]   cmd_len;
   logic [2:0]   cmd_size;
   logic [1:0]   cmd_burst;
   logic [31:0]  slv_w_data;
   logic [3:0]   slv_w_strb;
   logic         slv_w_last;
   logic [7:0]   slv_w_user;
   logic         slv_w_valid;
   logic         slv_w_ready_o;
   logic [255:0] mst_w_data_o;
   logic [31:0]  mst_w_strb_o;
   logic         mst_w_last_o;
   logic [7:0]   mst_w_user_o;
   logic         mst_w_valid_o;
   logic         mst_w_ready_i;
   logic         err_o;

   int total = 0;
   int bad   = 0;

   logic [255:0] q_data [$];
   logic [31:0]  q_strb [$];
   logic         q_last [$];
   logic [7:0]   q_user [$];

   axi_w_upsizer_packer #(
      .NarrowDataWidth (32),
      .WideDataWidth   (256),
      .UserWidth       (8),
      .CmdDepth        (2)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .cmd_valid_i   (cmd_valid),
      .cmd_ready_o   (cmd_ready_o),
      .cmd_offset_i  (cmd_offset),
      .cmd_len_i     (cmd_len),
      .cmd_size_i    (cmd_size),
      .cmd_burst_i   (cmd_burst),
      .slv_w_data_i  (slv_w_data),
      .slv_w_strb_i  (slv_w_strb),
      .slv_w_last_i  (slv_w_last),
      .slv_w_user_i  (slv_w_user),
      .slv_w_valid_i (slv_w_valid),
      .slv_w_ready_o (slv_w_ready_o),
      .mst_w_data_o  (mst_w_data_o),
      .mst_w_strb_o  (mst_w_strb_o),
      .mst_w_last_o  (mst_w_last_o),
      .mst_w_user_o  (mst_w_user_o),
      .mst_w_valid_o (mst_w_valid_o),
      .mst_w_ready_i (mst_w_ready_i),
      .err_o         (err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change just after posedge, so a beat seen valid&ready at negedge
   // is exactly the one taken at the following posedge.
   always @(negedge clk) begin
      if (!rst && mst_w_valid_o && mst_w_ready_i) begin
         q_data.push_back(mst_w_data_o);
         q_strb.push_back(mst_w_strb_o);
         q_last.push_back(mst_w_last_o);
         q_user.push_back(mst_w_user_o);
      end
   end

   task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic push_cmd(input logic [4:0] off, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
      int n = 0;
      cmd_valid  = 1'b1;
      cmd_offset = off;
      cmd_len    = len;
      cmd_size   = size;
      cmd_burst  = burst;
      while (!cmd_ready_o && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 100) check_eq("cmd_accept", cmd_ready_o, 1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic send_beat(input logic [31:0] d, input logic [3:0] s,
                            input logic l, input logic [7:0] u);
      int n = 0;
      slv_w_valid = 1'b1;
      slv_w_data  = d;
      slv_w_strb  = s;
      slv_w_last  = l;
      slv_w_user  = u;
      while (!slv_w_ready_o && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 100) check_eq("beat_accept", slv_w_ready_o, 1);
      @(posedge clk); #1;
      slv_w_valid = 1'b0;
   endtask

   task automatic wait_beats(input string tag, input int n);
      int k = 0;
      while (q_data.size() < n && k < 300) begin
         @(posedge clk); #1;
         k++;
      end
      repeat (3) begin @(posedge clk); #1; end
      check_eq({tag, "_count"}, 256'(q_data.size()), 256'(n));
   endtask

   task automatic check_beat(input string tag, input logic [255:0] d, input logic [31:0] s,
                             input logic l, input logic [7:0] u);
      if (q_data.size() == 0) begin
         check_eq({tag, "_present"}, 256'(q_data.size()), 256'd1);
      end else begin
         check_eq({tag, "_data"}, q_data.pop_front(), d);
         check_eq({tag, "_strb"}, q_strb.pop_front(), s);
         check_eq({tag, "_last"}, q_last.pop_front(), l);
         check_eq({tag, "_user"}, q_user.pop_front(), u);
      end
   endtask

   logic [255:0] exp_a;
   logic [255:0] exp_b;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      cmd_valid = 0; cmd_offset = 0; cmd_len = 0; cmd_size = 0; cmd_burst = 0;
      slv_w_valid = 0; slv_w_data = 0; slv_w_strb = 0; slv_w_last = 0; slv_w_user = 0;
      mst_w_ready_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_slv_ready", slv_w_ready_o, 0);
      check_eq("rst_mst_valid", mst_w_valid_o, 0);
      check_eq("rst_cmd_ready", cmd_ready_o, 1);
      check_eq("rst_err", err_o, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      check_eq("rel_cmd_ready", cmd_ready_o, 1);
      check_eq("rel_mst_valid", mst_w_valid_o, 0);

      // Narrow beats with no command are stalled.
      slv_w_valid = 1'b1; slv_w_data = 32'hDEADBEEF; slv_w_strb = 4'hF;
      repeat (3) begin @(posedge clk); #1; end
      check_eq("idle_stall", slv_w_ready_o, 0);
      slv_w_valid = 1'b0;

      // Full-width pack.
      push_cmd(5'h00, 8'd7, 3'd2, BURST_INCR);
      for (int i = 0; i < 8; i++) send_beat(32'h11111111 * 32'(i + 1), 4'hF, i == 7, 8'(i));
      wait_beats("full", 1);
      check_beat("full", 256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111,
                 32'hFFFFFFFF, 1'b1, 8'd7);

      // Wide boundary crossing.
      push_cmd(5'h1C, 8'd1, 3'd2, BURST_INCR);
      send_beat(32'hAAAAAAAA, 4'hF, 1'b0, 8'd0);
      send_beat(32'hBBBBBBBB, 4'hF, 1'b1, 8'd1);
      wait_beats("cross", 2);
      check_beat("cross0", {32'hAAAAAAAA, 224'h0}, 32'hF0000000, 1'b0, 8'd0);
      check_beat("cross1", {224'h0, 32'hBBBBBBBB}, 32'h0000000F, 1'b1, 8'd1);

      // Sub-width byte beats.
      push_cmd(5'h05, 8'd2, 3'd0, BURST_INCR);
      send_beat(32'h44332211, 4'h2, 1'b0, 8'd0);
      send_beat(32'h44332211, 4'h4, 1'b0, 8'd1);
      send_beat(32'h44332211, 4'h8, 1'b1, 8'd2);
      wait_beats("sub", 1);
      check_beat("sub", {192'h0, 64'h44332200_00000000}, 32'h000000E0, 1'b1, 8'd2);

      // FIXED burst: every narrow beat is its own wide beat.
      push_cmd(5'h08, 8'd2, 3'd2, BURST_FIXED);
      for (int i = 0; i < 3; i++) send_beat(32'h01010101 * 32'(i + 1), 4'hF, i == 2, 8'(i));
      wait_beats("fixed", 3);
      for (int i = 0; i < 3; i++)
         check_beat("fixed", {160'h0, 32'h01010101 * 32'(i + 1), 64'h0}, 32'h00000F00, i == 2, 8'(i));

      // Backpressure on the wide side.
      for (int i = 0; i < 8; i++) begin
         exp_a[i*32 +: 32] = 32'hC0DE0000 + 32'(i);
         exp_b[i*32 +: 32] = 32'hC0DE0008 + 32'(i);
      end
      mst_w_ready_i = 1'b0;
      push_cmd(5'h00, 8'd15, 3'd2, BURST_INCR);
      fork
         begin
            for (int i = 0; i < 16; i++) send_beat(32'hC0DE0000 + 32'(i), 4'hF, i == 15, 8'(i));
         end
         begin
            int k = 0;
            while (!mst_w_valid_o && k < 300) begin @(posedge clk); #1; k++; end
            check_eq("bp_valid", mst_w_valid_o, 1);
            repeat (10) begin
               @(posedge clk); #1;
               check_eq("bp_hold_data", mst_w_data_o, exp_a);
               check_eq("bp_hold_slv_ready", slv_w_ready_o, 0);
               check_eq("bp_hold_valid", mst_w_valid_o, 1);
            end
            mst_w_ready_i = 1'b1;
         end
      join
      wait_beats("bp", 2);
      check_beat("bp0", exp_a, 32'hFFFFFFFF, 1'b0, 8'd7);
      check_beat("bp1", exp_b, 32'hFFFFFFFF, 1'b1, 8'd15);

      // Reset in the middle of a burst.
      push_cmd(5'h00, 8'd3, 3'd2, BURST_INCR);
      send_beat(32'h12345678, 4'hF, 1'b0, 8'd0);
      send_beat(32'h9ABCDEF0, 4'hF, 1'b0, 8'd1);
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      check_eq("mid_rst_valid", mst_w_valid_o, 0);
      check_eq("mid_rst_slv_ready", slv_w_ready_o, 0);
      check_eq("mid_rst_cmd_ready", cmd_ready_o, 1);
      check_eq("mid_rst_data", mst_w_data_o, 0);
      check_eq("mid_rst_strb", mst_w_strb_o, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      check_eq("mid_rst_no_beat", 256'(q_data.size()), 256'd0);

      // Traffic resumes cleanly after reset.
      push_cmd(5'h00, 8'd0, 3'd2, BURST_INCR);
      send_beat(32'h5A5A5A5A, 4'hF, 1'b1, 8'h33);
      wait_beats("post_rst", 1);
      check_beat("post_rst", {224'h0, 32'h5A5A5A5A}, 32'h0000000F, 1'b1, 8'h33);

      // Command queue fills while the first burst waits for data.
      push_cmd(5'h00, 8'd0, 3'd2, BURST_INCR);
      push_cmd(5'h04, 8'd0, 3'd2, BURST_INCR);
      push_cmd(5'h08, 8'd0, 3'd2, BURST_INCR);
      check_eq("q_full", cmd_ready_o, 0);
      send_beat(32'hA0A0A0A0, 4'hF, 1'b1, 8'd1);
      send_beat(32'hB0B0B0B0, 4'hF, 1'b1, 8'd2);
      send_beat(32'hC0C0C0C0, 4'hF, 1'b1, 8'd3);
      wait_beats("queue", 3);
      check_beat("queue0", {224'h0, 32'hA0A0A0A0}, 32'h0000000F, 1'b1, 8'd1);
      check_beat("queue1", {192'h0, 32'hB0B0B0B0, 32'h0}, 32'h000000F0, 1'b1, 8'd2);
      check_beat("queue2", {160'h0, 32'hC0C0C0C0, 64'h0}, 32'h00000F00, 1'b1, 8'd3);
      check_eq("q_drained", cmd_ready_o, 1);

`ifdef AXI_W_UPSIZER_LAST_CHECK_EN
      // Early last: length counter terminates the burst and err_o latches.
      push_cmd(5'h00, 8'd3, 3'd2, BURST_INCR);
      send_beat(32'h00000001, 4'hF, 1'b0, 8'd0);
      send_beat(32'h00000002, 4'hF, 1'b1, 8'd1);
      check_eq("err_set", err_o, 1);
      send_beat(32'h00000003, 4'hF, 1'b0, 8'd2);
      send_beat(32'h00000004, 4'hF, 1'b0, 8'd3);
      wait_beats("mism", 1);
      check_beat("mism", {128'h0, 128'h00000004_00000003_00000002_00000001},
                 32'h0000FFFF, 1'b1, 8'd3);
      check_eq("err_sticky", err_o, 1);
`else
      push_cmd(5'h00, 8'd3, 3'd2, BURST_INCR);
      for (int i = 0; i < 4; i++) send_beat(32'(i + 1), 4'hF, i == 3, 8'(i));
      wait_beats("len4", 1);
      check_beat("len4", {128'h0, 128'h00000004_00000003_00000002_00000001},
                 32'h0000FFFF, 1'b1, 8'd3);
      check_eq("err_tied", err_o, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
